// File: rtl/fetch_pkg.sv
// Shared entry type and constants for the instruction prefetch buffer.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
    } fetch_entry_t;

    // Counters are sized for the largest legal NUM_REQS (8) and must hold 0..8.
    localparam int          MAX_REQS  = 8;
    localparam int          OUT_CNT_W = $clog2(MAX_REQS + 1);
    localparam logic [31:0] WORD_INC  = 32'd4;

endpackage

// File: rtl/prefetch_fifo.sv
// Shift-register FIFO of fetch entries; slot 0 is always the head, so the
// head is a plain register with no read multiplexer.
module prefetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 push,
    input  fetch_entry_t         push_data,
    input  logic                 pop,
    input  logic                 clear,
    output logic [OUT_CNT_W-1:0] count,
    output fetch_entry_t         head
);

    localparam logic [OUT_CNT_W-1:0] CNT_ONE = OUT_CNT_W'(1);

    fetch_entry_t         mem [DEPTH];
    logic                 push_en;
    logic                 pop_en;
    logic [OUT_CNT_W-1:0] wr_idx;

    assign pop_en  = pop && !clear && (count != '0);
    assign push_en = push && !clear && ((count < OUT_CNT_W'(DEPTH)) || pop_en);
    // A simultaneous pop shifts everything down, so the write lands one slot lower.
    assign wr_idx  = pop_en ? count - CNT_ONE : count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push_en && !pop_en) begin
            count <= count + CNT_ONE;
        end else if (pop_en && !push_en) begin
            count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_en && (wr_idx == OUT_CNT_W'(i))) begin
                mem[i] <= push_data;
            end else if (pop_en) begin
                mem[i] <= mem[(i < DEPTH - 1) ? i + 1 : i];
            end
        end
    end

    assign head = mem[0];

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer: in-order word fetches on the instruction bus,
// responses queued for the fetch stage. Macro PREFETCH_BUS_ERR_EN carries bus
// errors per entry and halts fetching after an error until the next redirect.
module instr_prefetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0,
    parameter int          NUM_REQS = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        instr_req_o,
    input  logic        instr_gnt_i,
    output logic [31:0] instr_addr_o,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    input  logic        instr_rvalid_i
);

    localparam logic [OUT_CNT_W-1:0] CNT_ONE = OUT_CNT_W'(1);
    localparam logic [OUT_CNT_W:0]   CREDITS = (OUT_CNT_W + 1)'(NUM_REQS);

    logic [31:0]          fetch_addr_q;
    logic [31:0]          resp_addr_q;
    logic [31:0]          branch_target;
    logic [OUT_CNT_W-1:0] out_cnt_q;
    logic [OUT_CNT_W-1:0] out_cnt_nxt;
    logic [OUT_CNT_W-1:0] disc_cnt_q;
    logic [OUT_CNT_W-1:0] fifo_cnt;
    logic [OUT_CNT_W:0]   in_use;
    logic                 stop;
    logic                 grant;
    logic                 rvalid_ok;
    logic                 drop;
    logic                 push;
    logic                 pop;
    fetch_entry_t         push_entry;
    fetch_entry_t         head;
    logic                 unused_bits;

    assign branch_target = {branch_addr_i[31:2], 2'b00};

    // Slots already spoken for: in flight on the bus plus waiting in the FIFO.
    assign in_use      = {1'b0, out_cnt_q} + {1'b0, fifo_cnt};
    assign instr_req_o = req_i && !stop && !branch_i && (in_use < CREDITS);
    assign grant       = instr_req_o && instr_gnt_i;
    assign rvalid_ok   = instr_rvalid_i && (out_cnt_q != '0);
    assign drop        = rvalid_ok && (disc_cnt_q != '0);
    assign push        = rvalid_ok && !drop && !branch_i;
    assign pop         = valid_o && ready_i && !branch_i;

    always_comb begin
        out_cnt_nxt = out_cnt_q;
        if (grant && !rvalid_ok) begin
            out_cnt_nxt = out_cnt_q + CNT_ONE;
        end else if (!grant && rvalid_ok) begin
            out_cnt_nxt = out_cnt_q - CNT_ONE;
        end
    end

    // resp_addr_q tracks the address of the next kept response; responses still
    // owed from before a redirect are all dropped before new ones arrive.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_addr_q <= {PC_RESET[31:2], 2'b00};
            resp_addr_q  <= {PC_RESET[31:2], 2'b00};
            out_cnt_q    <= '0;
            disc_cnt_q   <= '0;
        end else begin
            out_cnt_q <= out_cnt_nxt;
            if (branch_i) begin
                fetch_addr_q <= branch_target;
                resp_addr_q  <= branch_target;
                disc_cnt_q   <= out_cnt_nxt;
            end else begin
                if (grant) fetch_addr_q <= fetch_addr_q + WORD_INC;
                if (push)  resp_addr_q  <= resp_addr_q + WORD_INC;
                if (drop)  disc_cnt_q   <= disc_cnt_q - CNT_ONE;
            end
        end
    end

`ifdef PREFETCH_BUS_ERR_EN
    logic stop_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stop_q <= 1'b0;
        end else if (branch_i) begin
            stop_q <= 1'b0;
        end else if (push && instr_err_i) begin
            stop_q <= 1'b1;
        end
    end

    assign stop        = stop_q;
    assign push_entry  = '{addr: resp_addr_q, rdata: instr_rdata_i, err: instr_err_i};
    assign err_o       = valid_o && head.err;
    assign unused_bits = ^branch_addr_i[1:0];
`else
    assign stop        = 1'b0;
    assign push_entry  = '{addr: resp_addr_q, rdata: instr_rdata_i, err: 1'b0};
    assign err_o       = 1'b0;
    assign unused_bits = ^branch_addr_i[1:0] ^ instr_err_i ^ head.err;
`endif

    prefetch_fifo #(
        .DEPTH (NUM_REQS)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .clear     (branch_i),
        .count     (fifo_cnt),
        .head      (head)
    );

    assign valid_o      = (fifo_cnt != '0);
    assign rdata_o      = head.rdata;
    assign addr_o       = head.addr;
    assign busy_o       = (out_cnt_q != '0);
    assign instr_addr_o = fetch_addr_q;

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed self-checking bench for instr_prefetch (NUM_REQS=2, PC_RESET=0);
// the bus agent is driven cycle by cycle from each test task.
module tb_instr_prefetch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic [31:0] addr_o;
    logic        err_o;
    logic        busy_o;
    logic        instr_req_o;
    logic        instr_gnt_i;
    logic [31:0] instr_addr_o;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        instr_rvalid_i;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_prefetch #(
        .PC_RESET (32'h0),
        .NUM_REQS (2)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .branch_addr_i  (branch_addr_i),
        .ready_i        (ready_i),
        .valid_o        (valid_o),
        .rdata_o        (rdata_o),
        .addr_o         (addr_o),
        .err_o          (err_o),
        .busy_o         (busy_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i),
        .instr_rvalid_i (instr_rvalid_i)
    );

    // Memory contents seen by the bench's bus agent.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    // Drive one cycle of inputs just after the falling edge, then settle.
    task automatic drive(input logic rq, input logic gn, input logic rdy,
                         input logic rv, input logic [31:0] ra,
                         input logic br, input logic [31:0] ba, input logic er);
        @(negedge clk);
        req_i          = rq;
        instr_gnt_i    = gn;
        ready_i        = rdy;
        instr_rvalid_i = rv;
        instr_rdata_i  = rv ? word_at(ra) : 32'h0;
        branch_i       = br;
        branch_addr_i  = ba;
        instr_err_i    = er;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        idle();
        idle();
        tests++; if (instr_req_o !== 1'b0) begin fails++; $display("FAIL reset_req got=%b want=0", instr_req_o); end
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", valid_o); end
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", err_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy_o); end
        tests++; if (instr_addr_o !== 32'h0) begin fails++; $display("FAIL reset_addr got=%h want=00000000", instr_addr_o); end
        rstn = 1'b1;
    endtask

    task automatic test_stream();
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_req_o !== 1'b1) begin fails++; $display("FAIL stream_c0_req got=%b want=1", instr_req_o); end
        tests++; if (instr_addr_o !== 32'h0) begin fails++; $display("FAIL stream_c0_addr got=%h want=00000000", instr_addr_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL stream_c0_busy got=%b want=0", busy_o); end
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_req_o !== 1'b1) begin fails++; $display("FAIL stream_c1_req got=%b want=1", instr_req_o); end
        tests++; if (instr_addr_o !== 32'h4) begin fails++; $display("FAIL stream_c1_addr got=%h want=00000004", instr_addr_o); end
        tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL stream_c1_busy got=%b want=1", busy_o); end
        drive(1, 1, 1, 1, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_req_o !== 1'b0) begin fails++; $display("FAIL stream_c2_credit got=%b want=0", instr_req_o); end
        tests++; if (instr_addr_o !== 32'h8) begin fails++; $display("FAIL stream_c2_addr got=%h want=00000008", instr_addr_o); end
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL stream_c2_nobypass got=%b want=0", valid_o); end
        drive(1, 1, 1, 1, 32'h4, 0, 32'h0, 0);
        tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL stream_c3_valid got=%b want=1", valid_o); end
        tests++; if (addr_o !== 32'h0) begin fails++; $display("FAIL stream_c3_addr_o got=%h want=00000000", addr_o); end
        tests++; if (rdata_o !== word_at(32'h0)) begin fails++; $display("FAIL stream_c3_rdata got=%h want=%h", rdata_o, word_at(32'h0)); end
        tests++; if (instr_req_o !== 1'b0) begin fails++; $display("FAIL stream_c3_req got=%b want=0", instr_req_o); end
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL stream_c4_pushpop_valid got=%b want=1", valid_o); end
        tests++; if (addr_o !== 32'h4) begin fails++; $display("FAIL stream_c4_addr_o got=%h want=00000004", addr_o); end
        tests++; if (rdata_o !== word_at(32'h4)) begin fails++; $display("FAIL stream_c4_rdata got=%h want=%h", rdata_o, word_at(32'h4)); end
        tests++; if (instr_req_o !== 1'b1) begin fails++; $display("FAIL stream_c4_req got=%b want=1", instr_req_o); end
        tests++; if (instr_addr_o !== 32'h8) begin fails++; $display("FAIL stream_c4_addr got=%h want=00000008", instr_addr_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL stream_c4_busy got=%b want=0", busy_o); end
        drive(0, 0, 1, 1, 32'h8, 0, 32'h0, 0);
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL stream_c5_valid got=%b want=0", valid_o); end
        idle();
        tests++; if (valid_o !== 1'b1 || addr_o !== 32'h8) begin fails++; $display("FAIL stream_c6_head got=%b/%h want=1/00000008", valid_o, addr_o); end
        idle();
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL stream_c7_drained got=%b want=0", valid_o); end
    endtask

    task automatic test_backpressure();
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'hC) begin fails++; $display("FAIL bp_d0 got=%b/%h want=1/0000000c", instr_req_o, instr_addr_o); end
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        drive(1, 1, 0, 1, 32'hC, 0, 32'h0, 0);
        tests++; if (instr_req_o !== 1'b0) begin fails++; $display("FAIL bp_d2_req got=%b want=0", instr_req_o); end
        drive(1, 1, 0, 1, 32'h10, 0, 32'h0, 0);
        tests++; if (instr_req_o !== 1'b0) begin fails++; $display("FAIL bp_d3_req got=%b want=0", instr_req_o); end
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_req_o !== 1'b0) begin fails++; $display("FAIL bp_full_req got=%b want=0", instr_req_o); end
        tests++; if (valid_o !== 1'b1 || addr_o !== 32'hC) begin fails++; $display("FAIL bp_full_head got=%b/%h want=1/0000000c", valid_o, addr_o); end
        tests++; if (busy_o !== 1'b0) begin fails++; $display("FAIL bp_full_busy got=%b want=0", busy_o); end
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_req_o !== 1'b0) begin fails++; $display("FAIL bp_pop_cycle_req got=%b want=0", instr_req_o); end
        drive(1, 0, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h14) begin fails++; $display("FAIL bp_rise got=%b/%h want=1/00000014", instr_req_o, instr_addr_o); end
        tests++; if (addr_o !== 32'h10) begin fails++; $display("FAIL bp_second_head got=%h want=00000010", addr_o); end
        idle();
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL bp_drained got=%b want=0", valid_o); end
    endtask

    task automatic test_stall();
        drive(1, 0, 1, 0, 32'h0, 1, 32'h8, 0);
        tests++; if (instr_req_o !== 1'b0) begin fails++; $display("FAIL stall_branch_req got=%b want=0", instr_req_o); end
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 0, 32'h0, 0, 32'h0, 0);
            tests++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h8) begin fails++; $display("FAIL stall_hold%0d got=%b/%h want=1/00000008", i, instr_req_o, instr_addr_o); end
        end
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_addr_o !== 32'h8) begin fails++; $display("FAIL stall_grant_addr got=%h want=00000008", instr_addr_o); end
        drive(0, 0, 1, 1, 32'h8, 0, 32'h0, 0);
        idle();
        tests++; if (valid_o !== 1'b1 || addr_o !== 32'h8 || rdata_o !== word_at(32'h8)) begin fails++; $display("FAIL stall_entry got=%b/%h/%h want=1/00000008/%h", valid_o, addr_o, rdata_o, word_at(32'h8)); end
        idle();
        tests++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL stall_drained got=%b/%b want=0/0", valid_o, busy_o); end
    endtask

    task automatic test_branch_flush();
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_addr_o !== 32'h10) begin fails++; $display("FAIL flush_second_addr got=%h want=00000010", instr_addr_o); end
        drive(1, 1, 1, 0, 32'h0, 1, 32'h0000_0102, 0);
        tests++; if (instr_req_o !== 1'b0 || busy_o !== 1'b1) begin fails++; $display("FAIL flush_branch got=%b/%b want=0/1", instr_req_o, busy_o); end
        drive(1, 0, 1, 1, 32'hC, 0, 32'h0, 0);
        tests++; if (instr_addr_o !== 32'h100) begin fails++; $display("FAIL flush_target got=%h want=00000100", instr_addr_o); end
        tests++; if (instr_req_o !== 1'b0) begin fails++; $display("FAIL flush_credit got=%b want=0", instr_req_o); end
        drive(1, 0, 1, 1, 32'h10, 0, 32'h0, 0);
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL flush_drop1 got=%b want=0", valid_o); end
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL flush_drop2 got=%b/%b want=0/0", valid_o, busy_o); end
        tests++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin fails++; $display("FAIL flush_new_req got=%b/%h want=1/00000100", instr_req_o, instr_addr_o); end
        drive(0, 0, 1, 1, 32'h100, 0, 32'h0, 0);
        idle();
        tests++; if (valid_o !== 1'b1 || addr_o !== 32'h100 || rdata_o !== word_at(32'h100)) begin fails++; $display("FAIL flush_new_entry got=%b/%h/%h want=1/00000100/%h", valid_o, addr_o, rdata_o, word_at(32'h100)); end
        idle();
    endtask

    task automatic test_branch_grant();
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_addr_o !== 32'h104) begin fails++; $display("FAIL bg_addr got=%h want=00000104", instr_addr_o); end
        drive(1, 1, 1, 0, 32'h0, 1, 32'h200, 0);
        tests++; if (instr_req_o !== 1'b0) begin fails++; $display("FAIL bg_branch_req got=%b want=0", instr_req_o); end
        drive(0, 0, 1, 1, 32'h104, 0, 32'h0, 0);
        tests++; if (busy_o !== 1'b1 || instr_addr_o !== 32'h200) begin fails++; $display("FAIL bg_after got=%b/%h want=1/00000200", busy_o, instr_addr_o); end
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL bg_dropped got=%b/%b want=0/0", valid_o, busy_o); end
        drive(0, 0, 1, 1, 32'h200, 0, 32'h0, 0);
        idle();
        tests++; if (valid_o !== 1'b1 || addr_o !== 32'h200) begin fails++; $display("FAIL bg_kept got=%b/%h want=1/00000200", valid_o, addr_o); end
        idle();
    endtask

    task automatic test_spurious();
        drive(0, 0, 1, 1, 32'h55, 0, 32'h0, 0);
        drive(1, 0, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (valid_o !== 1'b0 || busy_o !== 1'b0) begin fails++; $display("FAIL spur_ignored got=%b/%b want=0/0", valid_o, busy_o); end
        tests++; if (instr_req_o !== 1'b1) begin fails++; $display("FAIL spur_no_underflow got=%b want=1", instr_req_o); end
        idle();
    endtask

    task automatic test_bus_error();
        drive(0, 0, 0, 0, 32'h0, 1, 32'h10, 0);
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h10) begin fails++; $display("FAIL err_req got=%b/%h want=1/00000010", instr_req_o, instr_addr_o); end
`ifdef PREFETCH_BUS_ERR_EN
        drive(1, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        drive(1, 1, 0, 1, 32'h10, 0, 32'h0, 1);
        drive(1, 1, 0, 1, 32'h14, 0, 32'h0, 0);
        tests++; if (valid_o !== 1'b1 || addr_o !== 32'h10 || err_o !== 1'b1) begin fails++; $display("FAIL err_head got=%b/%h/%b want=1/00000010/1", valid_o, addr_o, err_o); end
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_req_o !== 1'b0) begin fails++; $display("FAIL err_stop1 got=%b want=0", instr_req_o); end
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (addr_o !== 32'h14 || err_o !== 1'b0) begin fails++; $display("FAIL err_clean_entry got=%h/%b want=00000014/0", addr_o, err_o); end
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (valid_o !== 1'b0 || instr_req_o !== 1'b0) begin fails++; $display("FAIL err_stop2 got=%b/%b want=0/0", valid_o, instr_req_o); end
        drive(1, 0, 1, 0, 32'h0, 1, 32'h40, 0);
        drive(1, 0, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h40) begin fails++; $display("FAIL err_restart got=%b/%h want=1/00000040", instr_req_o, instr_addr_o); end
`else
        drive(0, 0, 1, 1, 32'h10, 0, 32'h0, 1);
        drive(1, 0, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (valid_o !== 1'b1 || addr_o !== 32'h10 || err_o !== 1'b0) begin fails++; $display("FAIL noerr_head got=%b/%h/%b want=1/00000010/0", valid_o, addr_o, err_o); end
        tests++; if (instr_req_o !== 1'b1) begin fails++; $display("FAIL noerr_no_stop got=%b want=1", instr_req_o); end
`endif
        idle();
    endtask

    task automatic test_reset_mid();
        drive(1, 1, 1, 0, 32'h0, 0, 32'h0, 0);
        idle();
        tests++; if (busy_o !== 1'b1) begin fails++; $display("FAIL rmid_busy got=%b want=1", busy_o); end
        rstn = 1'b0;
        #1;
        tests++; if (busy_o !== 1'b0 || instr_addr_o !== 32'h0 || valid_o !== 1'b0) begin fails++; $display("FAIL rmid_state got=%b/%h/%b want=0/00000000/0", busy_o, instr_addr_o, valid_o); end
        idle();
        rstn = 1'b1;
        drive(1, 0, 1, 0, 32'h0, 0, 32'h0, 0);
        tests++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0) begin fails++; $display("FAIL rmid_restart got=%b/%h want=1/00000000", instr_req_o, instr_addr_o); end
        idle();
    endtask

    initial begin
        rstn           = 1'b0;
        req_i          = 1'b0;
        branch_i       = 1'b0;
        branch_addr_i  = 32'h0;
        ready_i        = 1'b0;
        instr_gnt_i    = 1'b0;
        instr_rdata_i  = 32'h0;
        instr_err_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_stall();
        test_branch_flush();
        test_branch_grant();
        test_spurious();
        test_bus_error();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached after %0d tests", tests);
        $fatal(1);
    end

endmodule

// File: doc/instr_prefetch.md
INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter PC_RESET, default 32'h0: word-aligned fetch address after reset.
REQ-002 Parameter NUM_REQS, default 2: max outstanding bus requests, which is also the FIFO depth; legal 1..8.
REQ-003 clk  input  1  clock; all flops rising-edge.
REQ-004 rstn  input  1  reset, asynchronous, active-low.
REQ-005 req_i  input  1  fetch enable from the fetch stage; 0 blocks new bus requests.
REQ-006 branch_i  input  1  redirect strobe (branch, jump or trap), one cycle.
REQ-007 branch_addr_i  input  32  redirect target.
REQ-008 ready_i  input  1  fetch stage accepts the head entry.
REQ-009 valid_o  output  1  head entry valid.
REQ-010 rdata_o  output  32  head instruction word.
REQ-011 addr_o  output  32  word address of the head entry.
REQ-012 err_o  output  1  head entry carries a bus error.
REQ-013 busy_o  output  1  at least one request outstanding.
REQ-014 instr_req_o  output  1  bus request.
REQ-015 instr_gnt_i  input  1  bus grant.
REQ-016 instr_addr_o  output  32  bus address, bits [1:0] = 0.
REQ-017 instr_rdata_i  input  32  bus read data.
REQ-018 instr_err_i  input  1  bus error, qualified by rvalid.
REQ-019 instr_rvalid_i  input  1  bus response valid.

Function
REQ-020 The fetch address register shall hold the current bus address and shall drive instr_addr_o directly.
REQ-021 A request shall be raised when req_i=1, no stop is in effect, and outstanding + FIFO count < NUM_REQS; this credit rule ensures a response can never meet a full FIFO.
REQ-022 While instr_req_o=1 and instr_gnt_i=0, the request and address shall stay stable unless branch_i=1.
REQ-023 A grant (req & gnt) shall increment the outstanding count and advance the fetch address by 4, wrapping modulo 2^32.
REQ-024 Each instr_rvalid_i shall decrement the outstanding count.
REQ-025 A response shall be dropped if the discard count is non-zero, decrementing that count; otherwise it shall be pushed into the FIFO with its address.
REQ-026 A response arriving with outstanding = 0 shall be ignored, and no counter shall underflow.
REQ-027 Responses shall be in order; the stored address is the address captured at grant, held in an address FIFO or counter.
REQ-028 valid_o shall equal FIFO-not-empty; a pop occurs when valid_o & ready_i.
REQ-029 A push and a pop in the same cycle shall leave the count unchanged.
REQ-030 Latency: rvalid in cycle N gives valid_o in cycle N+1; there is no combinational bypass.
REQ-031 On branch_i, the FIFO shall clear, the fetch address shall load {branch_addr_i[31:2], 2'b00}, and the discard count shall load the post-update outstanding count, including a grant or rvalid in the same cycle.
REQ-032 On branch_i, instr_req_o shall be 0 in that cycle and may rise from the next cycle.
REQ-033 A branch takes priority over a simultaneous push, pop, or grant address increment.
REQ-034 busy_o shall equal (outstanding != 0).

Reset
REQ-035 Reset shall give: instr_req_o=0, valid_o=0, err_o=0, busy_o=0, fetch address = PC_RESET, FIFO empty, both counters 0, stop flag clear.
REQ-036 Reset asserted mid-transaction shall abandon in-flight requests; the bus agent is reset together with this block.

Configuration
REQ-037 With PREFETCH_BUS_ERR_EN defined, instr_err_i shall be stored per entry and output on err_o.
REQ-038 With PREFETCH_BUS_ERR_EN defined, pushing an error entry shall set the stop flag, which blocks new requests until branch_i.
REQ-039 Without PREFETCH_BUS_ERR_EN, err_o shall be tied to 0, instr_err_i shall be ignored, and no stop flag shall exist.

Structure
REQ-040 Package fetch_pkg shall hold: the fetch_entry_t struct {addr[31:0], rdata[31:0], err}, the width constant of the outstanding counter $clog2(NUM_REQS+1), and the word-increment constant 32'd4.
REQ-041 One sub-module, prefetch_fifo, shall be a parameterised synchronous FIFO of fetch_entry_t with push, pop, clear, count, and a registered head.

Verification
REQ-042 Reset release with req_i=1 and gnt tied high shall give instr_addr_o = 0, 4, 8 on consecutive cycles, at most 2 outstanding, and valid_o one cycle after the first rvalid.
REQ-043 With ready_i=0, two responses shall fill the FIFO and instr_req_o shall stay 0; with ready_i=1, instr_req_o shall rise in the next cycle.
REQ-044 With 2 outstanding, branch_i to 32'h0000_0102 shall drop both later responses (valid_o stays 0), then give instr_addr_o = 32'h0000_0100 and addr_o = 32'h0000_0100 on the first new entry.
REQ-045 Branch_i in the same cycle as a grant shall discard that granted response, setting the discard count to 1 with 1 outstanding.
REQ-046 With gnt held low for 5 cycles, instr_addr_o shall stay constant at 32'h0000_0008 and instr_req_o shall stay 1.
REQ-047 With PREFETCH_BUS_ERR_EN defined, rvalid with err=1 at 32'h0000_0010 shall give err_o=1 for that entry and no further requests until branch_i.
